// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// Instruction fetch stage: one outstanding imem request, a one-entry instruction
// buffer toward decode, and redirect handling that drops wrong-path responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        d_stall,
  output logic [31:0] f_instr,
  output logic [31:0] f_pc,
  output logic        f_stall,
  output logic        f_flush
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic        accept;
  logic [31:0] redirect_target;

  assign redirect_target = redirect_pc & ~32'd3;

  // A request only goes out when the buffer is empty or draining, so a later
  // capture can never land on a still-valid instruction.
  assign imem_req  = (state_q == S_REQ) && (!buf_valid_q || !d_stall) && !reset;
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ready;

  assign f_instr = buf_instr_q;
  assign f_pc    = buf_pc_q;
  assign f_stall = !buf_valid_q || reset;
  assign f_flush = redirect && !reset;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;

    if (buf_valid_q && !d_stall) begin
      buf_valid_d = 1'b0;
    end

    if (redirect) begin
      fetch_pc_d  = redirect_target;
      buf_valid_d = 1'b0;
      // An old-address request still in flight must have its response dropped.
      case (state_q)
        S_REQ:   state_d = accept ? S_DROP : S_REQ;
        S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DROP;
        default: state_d = S_DROP;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (accept) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_INC;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = req_pc_q;
            buf_valid_d = 1'b1;
            state_d     = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= '0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// Directed bench for fetch_unit: behavioural imem with programmable latency and a
// scoreboard of expected PCs popped whenever decode consumes an instruction.
module tb_fetch_unit;

  localparam logic [31:0] MASK     = 32'hA5A5_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        d_stall;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        f_stall;
  logic        f_flush;

  fetch_unit #(
    .RESET_PC(RESET_PC),
    .PC_INC  (32'd4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .d_stall    (d_stall),
    .f_instr    (f_instr),
    .f_pc       (f_pc),
    .f_stall    (f_stall),
    .f_flush    (f_flush)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  int unsigned cycle_n = 0;
  int unsigned last_consume = 0;
  bit          gap_en = 1'b0;
  int          lat = 1;
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Mid-cycle: score consumed instructions and let the memory model accept.
  task automatic sample();
    logic [31:0] exp;
    @(negedge clock);
    cycle_n++;
    if (reset) begin
      mem_busy = 1'b0;
    end else begin
      if (!f_stall && !d_stall && !redirect) begin
        check1("sb_underflow", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          exp = sb.pop_front();
          check("f_pc", f_pc, exp);
          check("f_instr", f_instr, exp ^ MASK);
          if (gap_en && last_consume != 0)
            check("consume_gap", 32'(cycle_n - last_consume), 32'd2);
          last_consume = cycle_n;
        end
      end
      if (imem_req && imem_ready) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = lat;
      end
    end
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom();
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_addr ^ MASK;
        mem_busy    = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic run_until_empty(input string tag, input int max_cycles);
    int n = 0;
    while (sb.size() > 0 && n < max_cycles) begin
      cyc();
      n++;
    end
    check1(tag, sb.size() == 0, 1'b1);
  endtask

  initial begin
    reset       = 1'b1;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2000;
    d_stall     = 1'b0;

    // Reset: outputs quiet even with redirect asserted
    sample();
    check1("rst_req", imem_req, 1'b0);
    check1("rst_stall", f_stall, 1'b1);
    check1("rst_flush", f_flush, 1'b0);
    advance();
    redirect = 1'b0;
    sample();
    check("rst_f_pc", f_pc, 32'h0);
    check("rst_f_instr", f_instr, 32'h0);
    advance();
    reset = 1'b0;

    // Sequential fetch, 1-cycle latency, no stall
    sb.push_back(32'h0000_1000);
    sb.push_back(32'h0000_1004);
    sb.push_back(32'h0000_1008);
    gap_en = 1'b1;
    sample();
    check1("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, RESET_PC);
    advance();
    run_until_empty("drain_seq", 20);
    gap_en = 1'b0;

    // Decode stall holds the buffer and blocks requests
    d_stall = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      sample();
      check("stall_f_pc", f_pc, 32'h0000_100C);
      check("stall_f_instr", f_instr, 32'h0000_100C ^ MASK);
      check1("stall_req", imem_req, 1'b0);
      check1("stall_f_stall", f_stall, 1'b0);
      advance();
    end
    sb.push_back(32'h0000_100C);
    d_stall = 1'b0;
    sample();
    check1("release_req", imem_req, 1'b1);
    check("release_addr", imem_addr, 32'h0000_1010);
    advance();

    // Redirect while waiting on a slow response; stale word arrives later
    sb.push_back(32'h0000_1010);
    lat = 4;
    run_until_empty("drain_1010", 10);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2002;
    sb.push_back(32'h0000_2000);
    sample();
    check1("wait_redir_flush", f_flush, 1'b1);
    check1("wait_redir_req", imem_req, 1'b0);
    advance();
    redirect    = 1'b0;
    redirect_pc = $urandom();
    sample();
    check1("post_redir_flush", f_flush, 1'b0);
    check1("drop_req0", imem_req, 1'b0);
    advance();
    sample();
    check1("drop_req1", imem_req, 1'b0);
    advance();
    lat = 1;
    sample();
    check1("drop_req2", imem_req, 1'b0);
    advance();
    sample();
    check1("after_drop_req", imem_req, 1'b1);
    check("after_drop_addr", imem_addr, 32'h0000_2000);
    advance();
    run_until_empty("drain_2000", 10);

    // Redirect in the same cycle the old address is accepted
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3000;
    sample();
    check1("acc_redir_req", imem_req, 1'b1);
    check("acc_redir_old_addr", imem_addr, 32'h0000_2008);
    check1("acc_redir_flush", f_flush, 1'b1);
    advance();
    redirect = 1'b0;
    sb.push_back(32'h0000_3000);
    sample();
    check1("acc_drop_req", imem_req, 1'b0);
    advance();
    sample();
    check1("acc_new_req", imem_req, 1'b1);
    check("acc_new_addr", imem_addr, 32'h0000_3000);
    advance();
    run_until_empty("drain_3000", 10);

    // Redirect coincident with rvalid in WAIT, then wrap past 0xFFFF_FFFC
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    sb.push_back(32'hFFFF_FFF8);
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0000_0000);
    sample();
    check1("wrap_redir_flush", f_flush, 1'b1);
    advance();
    redirect = 1'b0;
    sample();
    check1("wrap_req", imem_req, 1'b1);
    check("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    advance();
    run_until_empty("drain_wrap", 20);

    // Reset with a valid, stalled buffer
    d_stall = 1'b1;
    cyc();
    sample();
    check1("pre_rst_stall", f_stall, 1'b0);
    check("pre_rst_f_pc", f_pc, 32'h0000_0004);
    check1("pre_rst_req", imem_req, 1'b0);
    advance();
    reset = 1'b1;
    sample();
    check1("mid_rst_stall", f_stall, 1'b1);
    check1("mid_rst_req", imem_req, 1'b0);
    check1("mid_rst_flush", f_flush, 1'b0);
    advance();
    reset   = 1'b0;
    d_stall = 1'b0;
    sb.push_back(RESET_PC);
    sample();
    check1("post_rst_stall", f_stall, 1'b1);
    check1("post_rst_req", imem_req, 1'b1);
    check("post_rst_addr", imem_addr, RESET_PC);
    advance();
    run_until_empty("drain_post_rst", 10);

    check1("sb_empty", sb.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
